// File: rtl/enc_pkg.sv
// Shared types, defaults and the rotate helper for the encryption scrambler.
// Optional feature macro used by this block: ENC_MAC_EN.
package enc_pkg;

  localparam int N_DEFAULT   = 8;
  localparam int ROT_DEFAULT = 3;

  typedef logic [N_DEFAULT-1:0] word_t;

  // Pure bit rotation of a default-width word; the amount wraps modulo the width.
  function automatic word_t rotl(input word_t word, input int unsigned amount);
    int unsigned sh;
    sh = amount % N_DEFAULT;
    if (sh == 0) begin
      return word;
    end
    return (word << sh) | (word >> (N_DEFAULT - sh));
  endfunction

endpackage

// File: rtl/enc_round.sv
// One scrambler round: s_out = rotl(s_in ^ rotl(key_in, ROUND mod N), ROT mod N), registered.
// The key (and mac under ENC_MAC_EN) travels with its own word into the next stage.
module enc_round
  import enc_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int ROT   = ROT_DEFAULT,
  parameter int ROUND = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] s_in,
  input  logic [N-1:0] key_in,
`ifdef ENC_MAC_EN
  input  logic [N-1:0] mac_in,
  output logic [N-1:0] mac_out,
`endif
  output logic [N-1:0] key_out,
  output logic [N-1:0] s_out
);

  localparam int unsigned RK_SH  = ROUND % N;
  localparam int unsigned ROT_SH = ROT % N;

  logic [N-1:0] rk;
  logic [N-1:0] mix;
  logic [N-1:0] s_next;

  assign mix = s_in ^ rk;

  // Default width uses the shared helper; other widths are plain wiring permutations.
  generate
    if (N == N_DEFAULT) begin : g_pkg_rot
      assign rk     = rotl(key_in, RK_SH);
      assign s_next = rotl(mix, ROT_SH);
    end else begin : g_generic_rot
      genvar i;
      for (i = 0; i < N; i++) begin : g_bit
        assign rk[(i + RK_SH) % N]      = key_in[i];
        assign s_next[(i + ROT_SH) % N] = mix[i];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_out   <= '0;
      key_out <= '0;
    end else begin
      s_out   <= s_next;
      key_out <= key_in;
    end
  end

`ifdef ENC_MAC_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mac_out <= '0;
    end else begin
      mac_out <= mac_in;
    end
  end
`endif

endmodule

// File: rtl/encryption.sv
// Pipelined block scrambler: ROUNDS registered rounds, one {key,data} pair accepted per clock.
// ENC_MAC_EN adds mac/e_mac, where e_mac = ciphertext ^ the mac sampled with that word.
module encryption
  import enc_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int ROUNDS = 2,
  parameter int ROT    = ROT_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] key,
  input  logic [N-1:0] data,
`ifdef ENC_MAC_EN
  input  logic [N-1:0] mac,
  output logic [N-1:0] e_mac,
`endif
  output logic [N-1:0] e_data
);

  // Streaming interface without valid/ready: every rising edge samples key/data
  // (and mac), and e_data always shows the word sampled ROUNDS-1 edges before.
  logic [N-1:0] s_chain   [ROUNDS+1];
  logic [N-1:0] key_chain [ROUNDS+1];
  logic [N-1:0] key_unused;

  assign s_chain[0]   = data;
  assign key_chain[0] = key;

`ifdef ENC_MAC_EN
  logic [N-1:0] mac_chain [ROUNDS+1];
  assign mac_chain[0] = mac;
`endif

  generate
    for (genvar r = 0; r < ROUNDS; r++) begin : g_round
      enc_round #(
        .N     (N),
        .ROT   (ROT),
        .ROUND (r)
      ) u_round (
        .clock   (clock),
        .reset_n (reset_n),
        .s_in    (s_chain[r]),
        .key_in  (key_chain[r]),
`ifdef ENC_MAC_EN
        .mac_in  (mac_chain[r]),
        .mac_out (mac_chain[r+1]),
`endif
        .key_out (key_chain[r+1]),
        .s_out   (s_chain[r+1])
      );
    end
  endgenerate

  // The last stage's carried key has no consumer; synthesis trims it.
  assign key_unused = key_chain[ROUNDS];

  assign e_data = s_chain[ROUNDS];

`ifdef ENC_MAC_EN
  assign e_mac = s_chain[ROUNDS] ^ mac_chain[ROUNDS];
`endif

endmodule

// File: tb/tb_encryption.sv
// Self-checking bench for encryption (N=8, ROUNDS=2, ROT=3) against a behavioural model.
// Builds with or without ENC_MAC_EN.
module tb_encryption;

  localparam int N      = 8;
  localparam int ROUNDS = 2;
  localparam int ROT    = 3;
  localparam int W      = 2 * N;

  logic         clock;
  logic         reset_n;
  logic [N-1:0] key;
  logic [N-1:0] data;
  logic [N-1:0] e_data;
`ifdef ENC_MAC_EN
  logic [N-1:0] mac;
  logic [N-1:0] e_mac;
`endif

  int tests;
  int fails;

  // Each entry is {expected e_mac, expected e_data} for one sampled pair.
  logic [W-1:0] exp_q[$];

  encryption #(
    .N      (N),
    .ROUNDS (ROUNDS),
    .ROT    (ROT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .key     (key),
    .data    (data),
`ifdef ENC_MAC_EN
    .mac     (mac),
    .e_mac   (e_mac),
`endif
    .e_data  (e_data)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] rot_left(input logic [N-1:0] x, input int a);
    int sh;
    sh = a % N;
    if (sh == 0) return x;
    return (x << sh) | (x >> (N - sh));
  endfunction

  function automatic logic [N-1:0] model(input logic [N-1:0] k, input logic [N-1:0] d);
    logic [N-1:0] s;
    s = d;
    for (int r = 0; r < ROUNDS; r++) begin
      s = rot_left(s ^ rot_left(k, r), ROT);
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_rand();
    key  = N'($urandom_range(0, (1 << N) - 1));
    data = N'($urandom_range(0, (1 << N) - 1));
`ifdef ENC_MAC_EN
    mac  = N'($urandom_range(0, (1 << N) - 1));
`endif
  endtask

  task automatic drive(input logic [N-1:0] k, input logic [N-1:0] d, input logic [N-1:0] m);
    key  = k;
    data = d;
`ifdef ENC_MAC_EN
    mac  = m;
`else
    if (m != '0) begin
      key = k;
    end
`endif
  endtask

  // ---------------- scoreboard ----------------
  // Record every sampled pair; keep only the last ROUNDS, oldest one is on e_data.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      logic [N-1:0] c;
      logic [N-1:0] m;
      c = model(key, data);
`ifdef ENC_MAC_EN
      m = c ^ mac;
`else
      m = '0;
`endif
      exp_q.push_back({m, c});
      if (exp_q.size() > ROUNDS) void'(exp_q.pop_front());
    end
  end

  always @(negedge clock) begin
    logic [W-1:0] exp;
    exp = (exp_q.size() == ROUNDS) ? exp_q[0] : '0;
    check("stream_e_data", e_data, exp[N-1:0]);
`ifdef ENC_MAC_EN
    check("stream_e_mac", e_mac, exp[W-1:N]);
`endif
  end

  // ---------------- main sequence ----------------
  logic [N-1:0] k1;
  logic [N-1:0] d1;

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b1;
    drive('0, '0, '0);
    #1 reset_n = 1'b0;

    // Hand-computed values pin the model.
    check("model_00_01", model(8'h00, 8'h01), 8'h40);
    check("model_0f_02", model(8'h0F, 8'h02), 8'hB3);
    check("model_aa_55", model(8'hAA, 8'h55), 8'h55);

    // Reset held with toggling inputs.
    repeat (4) begin
      @(negedge clock);
      check("reset_hold_e_data", e_data, 8'h00);
`ifdef ENC_MAC_EN
      check("reset_hold_e_mac", e_mac, 8'h00);
`endif
      drive_rand();
    end

    // Back-to-back directed pairs right after release.
    @(negedge clock);
    reset_n = 1'b1;
    drive(8'h00, 8'h01, 8'h33);
    @(negedge clock);
    check("release_first_edge", e_data, 8'h00);
    drive(8'h0F, 8'h02, 8'hC4);
    @(negedge clock);
    check("pair_00_01", e_data, 8'h40);
    drive(8'hAA, 8'h55, 8'h0F);
    @(negedge clock);
    check("pair_0f_02", e_data, 8'hB3);
    drive_rand();
    @(negedge clock);
    check("pair_aa_55", e_data, 8'h55);
`ifdef ENC_MAC_EN
    check("mac_aa_55", e_mac, 8'h5A);
`endif
    drive_rand();

    // Random stream, first half.
    repeat (500) begin
      @(negedge clock);
      drive_rand();
    end

    // Asynchronous reset pulse mid-stream.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check("async_reset_e_data", e_data, 8'h00);
`ifdef ENC_MAC_EN
    check("async_reset_e_mac", e_mac, 8'h00);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    drive_rand();
    k1 = key;
    d1 = data;
    @(negedge clock);
    check("pulse_release_first_edge", e_data, 8'h00);
    drive_rand();
    @(negedge clock);
    check("pulse_release_second_edge", e_data, model(k1, d1));
    drive_rand();

    // Random stream, second half.
    repeat (500) begin
      @(negedge clock);
      drive_rand();
    end

    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
